// File: rtl/sequential_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider.
// State encoding, datapath width, counter width and a magnitude helper.
package sequential_divider_pkg;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // -2^31 maps onto 32'h8000_0000, which is still the right unsigned magnitude
    function automatic logic [DIV_W-1:0] mag(
        input logic [DIV_W-1:0] v,
        input logic             s
    );
        return (s && v[DIV_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/sequential_divider_dff_r_div_count.sv
// Iteration counter for the divider.
// Synchronous active-high reset plus a synchronous clear.
module sequential_divider_dff_r_div_count
    import sequential_divider_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// Radix-2 restoring divider, 32-bit, signed or unsigned.
// One quotient bit per cycle, sign fix-up in a dedicated FIX cycle.
module sequential_divider
    import sequential_divider_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic             is_signed,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             busy,
    output logic             op_done,
    output logic             div_by_zero
);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] q_acc;
    logic [DIV_W-1:0] rem_acc;
    logic [DIV_W-1:0] b_mag;
    logic             q_neg;
    logic             r_neg;
    logic [DIV_W:0]   t;
    logic             last_iter;

    sequential_divider_dff_r_div_count u_count (
        .clk   (clk),
        .reset (reset),
        .clear (op_clear || (state != ST_EXEC)),
        .en    (state == ST_EXEC),
        .count (count)
    );

    assign last_iter = (count == '1);

    // t[DIV_W] is the sign: rem_acc < b_mag keeps the true difference in range
    assign t = {rem_acc, q_acc[DIV_W-1]} - {1'b0, b_mag};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        state_nxt = (divisor == '0) ? ST_DONE : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (last_iter) begin
                        state_nxt = ST_FIX;
                    end
                end
                ST_FIX:  state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || op_clear) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_acc       <= '0;
            rem_acc     <= '0;
            b_mag       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        q_neg <= is_signed
                               & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
                        r_neg <= is_signed & dividend[DIV_W-1];
                        b_mag <= mag(divisor, is_signed);
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_acc   <= mag(dividend, is_signed);
                            rem_acc <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (!t[DIV_W]) begin
                        rem_acc <= t[DIV_W-1:0];
                        q_acc   <= {q_acc[DIV_W-2:0], 1'b1};
                    end else begin
                        rem_acc <= {rem_acc[DIV_W-2:0], q_acc[DIV_W-1]};
                        q_acc   <= {q_acc[DIV_W-2:0], 1'b0};
                    end
                end
                ST_FIX: begin
                    quotient  <= q_neg ? -q_acc : q_acc;
                    remainder <= r_neg ? -rem_acc : rem_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state == ST_EXEC) || (state == ST_FIX);
    assign op_done = (state == ST_DONE);

endmodule
